// File: rtl/load_align_unit.sv
// Sequential LSU load formatter: issues one or two word-aligned memory reads,
// merges the words and returns the zero- or sign-extended load result.
module load_align_unit #(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter bit MISALIGN_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_ctrl,
   input  logic              flush,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_data,
   output logic              rsp_err
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ0  = 3'd1;
   localparam logic [2:0] S_WAIT0 = 3'd2;
   localparam logic [2:0] S_REQ1  = 3'd3;
   localparam logic [2:0] S_WAIT1 = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;
   localparam logic [2:0] S_DRAIN = 3'd6;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic [XLEN-1:0]   w0_q, w0_d;
   logic [XLEN-1:0]   w1_q, w1_d;
   logic              err_q, err_d;

   // True when a 'size' access starting at byte offset 'off' runs past the word.
   function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [1:0] size);
      logic [4:0] last;
      last = 5'(off) + (5'd1 << size);
      return last > 5'(NB);
   endfunction

   logic              accept;
   logic              req_illegal;
   logic              req_cross;
   logic              cur_cross;
   logic [ADDR_W-1:0] base_addr;

   assign req_ready   = (state_q == S_IDLE);
   assign accept      = req_valid && req_ready;
   assign req_illegal = (XLEN == 32) && (req_ctrl[1:0] == 2'b11);
   assign req_cross   = crosses(req_addr[OFF_W-1:0], req_ctrl[1:0]);
   assign cur_cross   = crosses(addr_q[OFF_W-1:0], ctrl_q[1:0]);
   assign base_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
      state_d = state_q;
      addr_d  = addr_q;
      ctrl_d  = ctrl_q;
      w0_d    = w0_q;
      w1_d    = w1_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d = req_addr;
               ctrl_d = req_ctrl;
               w0_d   = '0;
               w1_d   = '0;
               if (req_illegal || (req_cross && (MISALIGN_EN == 1'b0))) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = S_REQ0;
               end
            end
         end
         S_REQ0, S_REQ1: begin
            // A read accepted in the flush cycle still returns data that must be swallowed.
            if (flush)              state_d = mem_req_ready ? S_DRAIN : S_IDLE;
            else if (mem_req_ready) state_d = (state_q == S_REQ0) ? S_WAIT0 : S_WAIT1;
         end
         S_WAIT0: begin
            if (flush) begin
               state_d = mem_rsp_valid ? S_IDLE : S_DRAIN;
            end else if (mem_rsp_valid) begin
               w0_d    = mem_rsp_data;
               state_d = cur_cross ? S_REQ1 : S_RESP;
            end
         end
         S_WAIT1: begin
            if (flush) begin
               state_d = mem_rsp_valid ? S_IDLE : S_DRAIN;
            end else if (mem_rsp_valid) begin
               w1_d    = mem_rsp_data;
               state_d = S_RESP;
            end
         end
         S_RESP:  if (flush || rsp_ready) state_d = S_IDLE;
         S_DRAIN: if (mem_rsp_valid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      case (state_q)
         S_REQ0: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = base_addr;
         end
         S_REQ1: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = base_addr + ADDR_W'(NB);
         end
         default: ;
      endcase
   end

   // Formatting works only from captured registers, never from mem_rsp_data directly.
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] keep_mask;
   logic            kept_msb;
   logic [XLEN-1:0] fmt_data;

   always_comb begin
      shifted   = XLEN'({w1_q, w0_q} >> {addr_q[OFF_W-1:0], 3'b000});
      keep_mask = '0;
      kept_msb  = 1'b0;
      case (ctrl_q[1:0])
         2'b00: begin
            keep_mask[7:0] = '1;
            kept_msb       = shifted[7];
         end
         2'b01: begin
            keep_mask[15:0] = '1;
            kept_msb        = shifted[15];
         end
         2'b10: begin
            keep_mask[31:0] = '1;
            kept_msb        = shifted[31];
         end
         default: keep_mask = '1;
      endcase
      fmt_data = (shifted & keep_mask) | ((kept_msb && !ctrl_q[2]) ? ~keep_mask : '0);
   end

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_data  = (rsp_valid && !err_q) ? fmt_data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         ctrl_q  <= '0;
         w0_q    <= '0;
         w1_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q <= state_d;
         addr_q  <= addr_d;
         ctrl_q  <= ctrl_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: three instances (XLEN 32, XLEN 32 without
// misaligned support, XLEN 64) share one stimulus port and one memory model.
module tb_load_align_unit;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int sel    = 0;

   logic        req_valid    = 1'b0;
   logic [31:0] req_addr     = '0;
   logic [2:0]  req_ctrl     = '0;
   logic        flush        = 1'b0;
   logic        rsp_ready    = 1'b0;
   logic        mem_ready_en = 1'b1;
   logic        mem_hold     = 1'b0;

   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_data;
   logic        pending_v;
   logic [63:0] pending_d;
   logic [63:0] mem [logic [31:0]];
   logic [31:0] req_log [$];

   logic        a_req_ready, a_mem_req_valid, a_rsp_valid, a_rsp_err;
   logic [31:0] a_mem_req_addr, a_rsp_data;
   logic        b_req_ready, b_mem_req_valid, b_rsp_valid, b_rsp_err;
   logic [31:0] b_mem_req_addr, b_rsp_data;
   logic        c_req_ready, c_mem_req_valid, c_rsp_valid, c_rsp_err;
   logic [31:0] c_mem_req_addr;
   logic [63:0] c_rsp_data;

   logic        req_ready_m, mem_req_valid_m, rsp_valid_m, rsp_err_m;
   logic [31:0] mem_req_addr_m;
   logic [63:0] rsp_data_m;

   load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid && (sel == 0)), .req_ready(a_req_ready),
      .req_addr(req_addr), .req_ctrl(req_ctrl), .flush(flush && (sel == 0)),
      .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_ready_en && (sel == 0)),
      .mem_req_addr(a_mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid && (sel == 0)), .mem_rsp_data(mem_rsp_data[31:0]),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err)
   );

   load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) u_dut32_nomis (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid && (sel == 1)), .req_ready(b_req_ready),
      .req_addr(req_addr), .req_ctrl(req_ctrl), .flush(flush && (sel == 1)),
      .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_ready_en && (sel == 1)),
      .mem_req_addr(b_mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid && (sel == 1)), .mem_rsp_data(mem_rsp_data[31:0]),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
   );

   load_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1'b1)) u_dut64 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid && (sel == 2)), .req_ready(c_req_ready),
      .req_addr(req_addr), .req_ctrl(req_ctrl), .flush(flush && (sel == 2)),
      .mem_req_valid(c_mem_req_valid), .mem_req_ready(mem_ready_en && (sel == 2)),
      .mem_req_addr(c_mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid && (sel == 2)), .mem_rsp_data(mem_rsp_data),
      .rsp_valid(c_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(c_rsp_data), .rsp_err(c_rsp_err)
   );

   always_comb begin
      case (sel)
         1: begin
            req_ready_m = b_req_ready; mem_req_valid_m = b_mem_req_valid; mem_req_addr_m = b_mem_req_addr;
            rsp_valid_m = b_rsp_valid; rsp_data_m = {32'h0, b_rsp_data}; rsp_err_m = b_rsp_err;
         end
         2: begin
            req_ready_m = c_req_ready; mem_req_valid_m = c_mem_req_valid; mem_req_addr_m = c_mem_req_addr;
            rsp_valid_m = c_rsp_valid; rsp_data_m = c_rsp_data; rsp_err_m = c_rsp_err;
         end
         default: begin
            req_ready_m = a_req_ready; mem_req_valid_m = a_mem_req_valid; mem_req_addr_m = a_mem_req_addr;
            rsp_valid_m = a_rsp_valid; rsp_data_m = {32'h0, a_rsp_data}; rsp_err_m = a_rsp_err;
         end
      endcase
   end

   function automatic logic [63:0] mem_read(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 64'h0;
   endfunction

   // Memory answers in the cycle after it accepts a read unless mem_hold parks the data.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rsp_valid <= 1'b0;
         mem_rsp_data  <= '0;
         pending_v     <= 1'b0;
         pending_d     <= '0;
      end else begin
         mem_rsp_valid <= 1'b0;
         if (pending_v && !mem_hold) begin
            mem_rsp_valid <= 1'b1;
            mem_rsp_data  <= pending_d;
            pending_v     <= 1'b0;
         end
         if (mem_req_valid_m && mem_ready_en) begin
            req_log.push_back(mem_req_addr_m);
            if (mem_hold) begin
               pending_v <= 1'b1;
               pending_d <= mem_read(mem_req_addr_m);
            end else begin
               mem_rsp_valid <= 1'b1;
               mem_rsp_data  <= mem_read(mem_req_addr_m);
            end
         end
      end
   end

   typedef struct {
      int          sel;
      logic [31:0] addr;
      logic [2:0]  ctrl;
      logic [63:0] m0;
      logic [63:0] m1;
      logic [63:0] data;
      logic        err;
      int          lat;
      int          nreq;
      logic [31:0] a0;
   } vec_t;

   task automatic do_load(input logic [31:0] addr, input logic [2:0] ctrl,
                          output logic [63:0] data, output logic err, output int lat);
      @(negedge clk);
      req_log.delete();
      req_valid = 1'b1;
      req_addr  = addr;
      req_ctrl  = ctrl;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid_m && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      data = rsp_data_m;
      err  = rsp_err_m;
   endtask

   task automatic test_reset();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         checks++;
         if (req_ready_m !== 1'b1 || mem_req_valid_m !== 1'b0 || mem_req_addr_m !== 32'h0 ||
             rsp_valid_m !== 1'b0 || rsp_data_m !== 64'h0 || rsp_err_m !== 1'b0)
         begin
            errors++;
            $display("FAIL reset sel%0d: req_ready=%b mem_req_valid=%b mem_req_addr=%h rsp_valid=%b rsp_data=%h rsp_err=%b, expected 1/0/0/0/0/0",
                     s, req_ready_m, mem_req_valid_m, mem_req_addr_m, rsp_valid_m, rsp_data_m, rsp_err_m);
         end
      end
      sel = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_load_vectors();
      vec_t        v [16];
      logic [63:0] d;
      logic        e;
      int          lat;
      int          nb;
      logic [31:0] exp_a;
      v = '{
         '{0, 32'h101, 3'b000, 64'h8899AABB, 64'h0, 64'hFFFF_FFAA, 1'b0, 3, 1, 32'h100},
         '{0, 32'h101, 3'b100, 64'h8899AABB, 64'h0, 64'h0000_00AA, 1'b0, 3, 1, 32'h100},
         '{0, 32'h102, 3'b001, 64'h8899AABB, 64'h0, 64'hFFFF_8899, 1'b0, 3, 1, 32'h100},
         '{0, 32'h102, 3'b101, 64'h8899AABB, 64'h0, 64'h0000_8899, 1'b0, 3, 1, 32'h100},
         '{0, 32'h100, 3'b010, 64'h8899AABB, 64'h0, 64'h8899_AABB, 1'b0, 3, 1, 32'h100},
         '{0, 32'h103, 3'b010, 64'h44332211, 64'h88776655, 64'h7766_5544, 1'b0, 5, 2, 32'h100},
         '{0, 32'h103, 3'b001, 64'h44332211, 64'h88776655, 64'h0000_5544, 1'b0, 5, 2, 32'h100},
         '{0, 32'h103, 3'b000, 64'h44332211, 64'h88776655, 64'h0000_0044, 1'b0, 3, 1, 32'h100},
         '{1, 32'h103, 3'b010, 64'h44332211, 64'h88776655, 64'h0, 1'b1, 1, 0, 32'h100},
         '{1, 32'h100, 3'b010, 64'h44332211, 64'h88776655, 64'h4433_2211, 1'b0, 3, 1, 32'h100},
         '{1, 32'h102, 3'b001, 64'h44332211, 64'h88776655, 64'h0000_4433, 1'b0, 3, 1, 32'h100},
         '{0, 32'h100, 3'b011, 64'h44332211, 64'h88776655, 64'h0, 1'b1, 1, 0, 32'h100},
         '{2, 32'h000, 3'b011, 64'h8000000000000001, 64'h1122334455667788, 64'h8000000000000001, 1'b0, 3, 1, 32'h0},
         '{2, 32'h004, 3'b010, 64'h8000000000000001, 64'h1122334455667788, 64'hFFFFFFFF80000000, 1'b0, 3, 1, 32'h0},
         '{2, 32'h004, 3'b110, 64'h8000000000000001, 64'h1122334455667788, 64'h0000000080000000, 1'b0, 3, 1, 32'h0},
         '{2, 32'h006, 3'b010, 64'h8000000000000001, 64'h1122334455667788, 64'h0000000077888000, 1'b0, 5, 2, 32'h0}
      };
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         sel = v[i].sel;
         nb  = (v[i].sel == 2) ? 8 : 4;
         mem[v[i].a0] = v[i].m0;
         exp_a = v[i].a0 + 32'(nb);
         mem[exp_a] = v[i].m1;
         #1;
         checks++;
         if (req_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL vec%0d req_ready before accept: got %b expected 1", i, req_ready_m);
         end
         do_load(v[i].addr, v[i].ctrl, d, e, lat);
         checks++;
         if (d !== v[i].data) begin
            errors++;
            $display("FAIL vec%0d rsp_data: got %h expected %h", i, d, v[i].data);
         end
         checks++;
         if (e !== v[i].err) begin
            errors++;
            $display("FAIL vec%0d rsp_err: got %b expected %b", i, e, v[i].err);
         end
         checks++;
         if (lat != v[i].lat) begin
            errors++;
            $display("FAIL vec%0d latency: got %0d expected %0d", i, lat, v[i].lat);
         end
         checks++;
         if (req_log.size() != v[i].nreq) begin
            errors++;
            $display("FAIL vec%0d mem read count: got %0d expected %0d", i, req_log.size(), v[i].nreq);
         end
         for (int j = 0; j < req_log.size() && j < v[i].nreq; j++) begin
            exp_a = v[i].a0 + 32'(j * nb);
            checks++;
            if (req_log[j] !== exp_a) begin
               errors++;
               $display("FAIL vec%0d mem read %0d addr: got %h expected %h", i, j, req_log[j], exp_a);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      sel = 0;
      mem[32'h100] = 64'h44332211;
      req_log.delete();
      req_valid = 1'b1;
      req_addr  = 32'h100;
      req_ctrl  = 3'b010;
      rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 1;
      while (!rsp_valid_m && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rsp_valid_m !== 1'b1 || rsp_data_m !== 64'h44332211 || req_ready_m !== 1'b0) begin
            errors++;
            $display("FAIL rsp hold cycle %0d: valid=%b data=%h req_ready=%b, expected 1/44332211/0",
                     k, rsp_valid_m, rsp_data_m, req_ready_m);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready_m !== 1'b1 || rsp_valid_m !== 1'b0) begin
         errors++;
         $display("FAIL rsp release: req_ready=%b rsp_valid=%b, expected 1/0", req_ready_m, rsp_valid_m);
      end
      mem_ready_en = 1'b0;
      req_log.delete();
      req_valid = 1'b1;
      req_addr  = 32'h102;
      req_ctrl  = 3'b001;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (mem_req_valid_m !== 1'b1 || mem_req_addr_m !== 32'h100) begin
            errors++;
            $display("FAIL mem stall cycle %0d: mem_req_valid=%b addr=%h, expected 1/00000100",
                     k, mem_req_valid_m, mem_req_addr_m);
         end
         @(negedge clk);
      end
      mem_ready_en = 1'b1;
      n = 0;
      while (!rsp_valid_m && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rsp_valid_m !== 1'b1 || rsp_data_m !== 64'h4433 || req_log.size() != 1) begin
         errors++;
         $display("FAIL stalled LH: valid=%b data=%h reads=%0d, expected 1/0000000000004433/1",
                  rsp_valid_m, rsp_data_m, req_log.size());
      end
   endtask

   task automatic test_flush_drain();
      int          n;
      int          seen;
      logic [63:0] d;
      logic        e;
      int          lat;
      @(negedge clk);
      sel = 0;
      mem[32'h100] = 64'h44332211;
      mem[32'h104] = 64'h88776655;
      req_valid = 1'b1;
      req_addr  = 32'h103;
      req_ctrl  = 3'b010;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!(mem_req_valid_m && mem_req_addr_m == 32'h104) && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL flush setup: second read to 00000104 never issued");
      end
      mem_hold = 1'b1;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (req_ready_m !== 1'b0 || rsp_valid_m !== 1'b0) begin
         errors++;
         $display("FAIL flush in WAIT1: req_ready=%b rsp_valid=%b, expected 0/0 (drain)", req_ready_m, rsp_valid_m);
      end
      mem_hold = 1'b0;
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (rsp_valid_m) seen++;
      end
      checks++;
      if (seen != 0 || req_ready_m !== 1'b1) begin
         errors++;
         $display("FAIL drain: rsp_valid cycles=%0d req_ready=%b, expected 0/1", seen, req_ready_m);
      end
      do_load(32'h100, 3'b010, d, e, lat);
      checks++;
      if (d !== 64'h44332211 || e !== 1'b0 || lat != 3) begin
         errors++;
         $display("FAIL load after drain: data=%h err=%b lat=%0d, expected 44332211/0/3", d, e, lat);
      end
   endtask

   task automatic test_reset_midflight();
      logic [63:0] d;
      logic        e;
      int          lat;
      @(negedge clk);
      sel = 0;
      mem_hold  = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h100;
      req_ctrl  = 3'b010;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (req_ready_m !== 1'b1 || mem_req_valid_m !== 1'b0 || rsp_valid_m !== 1'b0) begin
         errors++;
         $display("FAIL reset in WAIT0: req_ready=%b mem_req_valid=%b rsp_valid=%b, expected 1/0/0",
                  req_ready_m, mem_req_valid_m, rsp_valid_m);
      end
      mem_hold = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_load(32'h101, 3'b100, d, e, lat);
      checks++;
      if (d !== 64'h22 || e !== 1'b0 || lat != 3) begin
         errors++;
         $display("FAIL load after reset: data=%h err=%b lat=%0d, expected 0000000000000022/0/3", d, e, lat);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_load_vectors();
      test_backpressure();
      test_flush_drain();
      test_reset_midflight();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
